// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the five-stage MIPS pipeline: load-use stall, taken-branch squash, dmem freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] WLAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       abandon, abandon_nxt;
  logic       tmo_set;
  logic       freeze, req;
  logic       load_use, taken, access;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign taken    = mem_branch & mem_zero;
  assign access   = mem_read | mem_write;

  // abandon marks the single RUN cycle after a timeout, when the stale access
  // still sits in EX/MEM and must drain as a bubble instead of re-freezing.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    abandon_nxt = 1'b0;
    tmo_set     = 1'b0;
    freeze      = 1'b0;
    req         = 1'b0;
    case (state)
      RUN: begin
        req = access;
        if (!abandon && access && !dmem_ready) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        req    = 1'b1;
        freeze = ~dmem_ready;
        if (dmem_ready) begin
          state_nxt = RUN;
        end else if (wcnt == WLAST) begin
          tmo_set     = 1'b1;
          abandon_nxt = 1'b1;
          state_nxt   = RUN;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      wcnt        <= 8'd0;
      abandon     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      abandon     <= abandon_nxt;
      mem_timeout <= mem_timeout | tmo_set;
    end
  end

  // Priority: freeze > taken > load_use; everything is quiet while in reset.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    dmem_req     = 1'b0;
    if (reset_n) begin
      dmem_req = req;
      if (freeze) begin
        pipe_freeze = 1'b1;
      end else if (taken) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = reset_n & ~pc_write;
  assign flush_inc = reset_n & taken & ~freeze;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Central stall/flush sequencer for the five-stage MIPS pipeline. It detects load-use hazards between ID and EX, squashes wrong-path instructions when a branch resolves taken in MEM, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. Its outputs drive the PC write enable and the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of MEM_WAIT cycles before the access is abandoned; legal range 2..255.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  pipeline clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in IF/ID.
- `id_uses_rt`  in  1  instruction in ID reads rt (R-type, beq, sw).
- `ex_mem_read`  in  1  ID/EX M-control MemRead.
- `ex_rt`  in  5  ID/EX destination rt.
- `mem_branch`, `mem_zero`  in  1 each  EX/MEM Branch control bit and zero flag.
- `mem_read`, `mem_write`  in  1 each  EX/MEM memory controls.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`, `if_id_write`  out  1 each  enables for the PC and IF/ID.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  zero the control fields on the next edge.
- `id_ex_bubble`  out  1  load ID/EX with a NOP.
- `pipe_freeze`  out  1  hold IF/ID, ID/EX and EX/MEM; MEM/WB loads a bubble.
- `dmem_req`  out  1  memory access request.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`, `flush_count`  out  CNT_W each  performance counters.

## Operation
- Terms:
  - `load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`
  - `taken = mem_branch & mem_zero`
  - `access = mem_read | mem_write`
- FSM states: RUN and MEM_WAIT. A wait counter `wcnt` (8 bits) is held in registers.
- RUN:
  - `freeze = access & ~dmem_ready`. If set, go to MEM_WAIT and set `wcnt = 1`.
- MEM_WAIT:
  - `freeze = ~dmem_ready`.
  - On `dmem_ready`, go to RUN.
  - Otherwise, if `wcnt == MEM_TIMEOUT-1`, set `mem_timeout`, go to RUN and deassert freeze. The MEM/WB stage then takes a bubble for that access (`pipe_freeze = 0`, access abandoned). Otherwise increment `wcnt`.
- `dmem_req = access` in RUN, and 1 throughout MEM_WAIT.
- Output priority is freeze > taken > load_use:
  - freeze: `pipe_freeze = 1`, `pc_write = 0`, `if_id_write = 0`, all flushes 0, bubble 0.
  - taken: all three flushes 1, `pc_write = 1`, `if_id_write = 1`, bubble 0. Any load-use in the same cycle is discarded because it lies on the wrong path.
  - load_use: `pc_write = 0`, `if_id_write = 0`, `id_ex_bubble = 1`.
  - none: `pc_write = 1`, `if_id_write = 1`, everything else 0.
- A branch that resolves while frozen is held in EX/MEM and takes effect on the first unfrozen cycle.
- `mem_timeout` is cleared only by reset.

## Timing
- All outputs are combinational from the inputs and the registered state; there is zero-cycle latency from hazard to stall.
- A load-use stall lasts exactly 1 cycle. On the next cycle the NOP is in EX, so `ex_mem_read = 0`.
- A memory access whose `dmem_ready` arrives N cycles after the access is presented freezes the pipeline for N cycles.
- Reset (any cycle, including mid-MEM_WAIT) while `reset_n = 0`:
  - Outputs forced: `pc_write = 0`, `if_id_write = 0`, all flushes and bubble 0, `pipe_freeze = 0`, `dmem_req = 0`.
  - On the next edge: state becomes RUN; `wcnt`, `mem_timeout` and both counters become 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_write = 0` outside reset.
  - `flush_count` increments on every cycle with `taken` applied.
  - Both counters saturate at all-ones.
- `HAZARD_PERF_CNT_EN` undefined: both counter outputs are constant 0 and no counter registers are synthesised.

## Test plan
- lw to $8 in EX with an add reading $8 in ID -> 1 cycle with `pc_write = 0`, `id_ex_bubble = 1`; next cycle `pc_write = 1`. The same case with `ex_rt = 0` -> no stall.
- beq in MEM with `mem_zero = 1` -> `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are 1 for 1 cycle; with a simultaneous load_use, `id_ex_bubble = 0`.
- sw in MEM with `dmem_ready` arriving 3 cycles later -> `pipe_freeze` high for exactly 3 cycles, `dmem_req` high for 4 cycles, then RUN.
- `dmem_ready` never asserted, `MEM_TIMEOUT = 16` -> freeze for 16 cycles, then `mem_timeout = 1` and it stays 1.
- Taken branch in EX/MEM during a freeze -> no flush while frozen; flushes fire on the first unfrozen cycle.
- `reset_n` low during MEM_WAIT -> next cycle state RUN, `dmem_req = 0`, `mem_timeout = 0`, counters 0. With `HAZARD_PERF_CNT_EN` defined, 5 stalls plus 2 flushes -> counters read 5 and 2.
